serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_pkg.sv | 18 +
 rtl/serial_gap_timer.sv | 30 +++
 rtl/serial_frame_rx.sv | 122 ++++++++++++
 tb/tb_serial_frame_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// State encoding, default sync marker and the saturating error-counter increment.
package serial_frame_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_HUNT    = 2'd0;
    localparam rx_state_t ST_PAYLOAD = 2'd1;
    localparam rx_state_t ST_CHECK   = 2'd2;
    localparam rx_state_t ST_COMMIT  = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serial_gap_timer.sv
// Inter-byte gap counter: cleared by every byte strobe, counts while enabled,
// and parks at TIMEOUT_CYCLES so it can never wrap back below the limit.
module serial_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/serial_frame_rx.sv
// Framed byte receiver: hunts for SYNC_BYTE, collects NUM_BYTES payload bytes and
// publishes them on a good frame. Build with SERIAL_FRAME_CHECKSUM_EN for a trailing XOR byte.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int         NUM_BYTES      = 64,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_data_ready,
    input  logic [7:0]             rx_data,
    output logic [8*NUM_BYTES-1:0] payload,
    output logic                   frame_valid,
    output logic                   frame_error,
    output logic [7:0]             error_count,
    output logic                   busy,
    output rx_state_t              dbg_state
);

    localparam int PW = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

    // Handshake: rx_data is qualified only by the one-cycle rx_data_ready strobe;
    // there is no backpressure, every strobe outside COMMIT is consumed.
    rx_state_t     state;
    logic [CW-1:0] byte_cnt;
    logic [PW-1:0] staging;
    logic          timer_en;
    logic          expired;
`ifdef SERIAL_FRAME_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign timer_en  = (state == ST_PAYLOAD) || (state == ST_CHECK);
    assign busy      = (state != ST_HUNT);
    assign dbg_state = state;

    serial_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (rx_data_ready),
        .enable  (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_HUNT;
            byte_cnt    <= '0;
            staging     <= '0;
            payload     <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            error_count <= '0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
                        byte_cnt <= '0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
                        csum     <= '0;
`endif
                        state    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // A strobe in the expiry cycle takes priority over the timeout.
                    if (rx_data_ready) begin
                        staging  <= (staging << 8) | PW'(rx_data);
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef SERIAL_FRAME_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
                        if (byte_cnt == LAST_IDX) state <= ST_CHECK;
`else
                        if (byte_cnt == LAST_IDX) state <= ST_COMMIT;
`endif
                    end else if (expired) begin
                        frame_error <= 1'b1;
                        error_count <= sat_inc8(error_count);
                        state       <= ST_HUNT;
                    end
                end
`ifdef SERIAL_FRAME_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_data_ready) begin
                        if (rx_data == csum) begin
                            state <= ST_COMMIT;
                        end else begin
                            frame_error <= 1'b1;
                            error_count <= sat_inc8(error_count);
                            state       <= ST_HUNT;
                        end
                    end else if (expired) begin
                        frame_error <= 1'b1;
                        error_count <= sat_inc8(error_count);
                        state       <= ST_HUNT;
                    end
                end
`endif
                ST_COMMIT: begin
                    payload     <= staging;
                    frame_valid <= 1'b1;
                    state       <= ST_HUNT;
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (NUM_BYTES=4, TIMEOUT_CYCLES=16); follows
// SERIAL_FRAME_CHECKSUM_EN so the same vectors run in either build.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    localparam int NB = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_data_ready = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [8*NB-1:0] payload;
    logic          frame_valid;
    logic          frame_error;
    logic [7:0]    error_count;
    logic          busy;
    rx_state_t     dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cnt   = 0;
    int fe_cnt   = 0;
    logic [31:0] exp_q[$];

    serial_frame_rx #(
        .NUM_BYTES(NB),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .payload       (payload),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .error_count   (error_count),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (frame_error) fe_cnt++;
        if (frame_valid) begin
            fv_cnt++;
            if (exp_q.size() > 0) check("sb_payload", payload, exp_q.pop_front());
            else check("sb_unexpected_valid", {31'd0, frame_valid}, 32'd0);
        end
    end

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        rx_data_ready = 1'b0;
        #3;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sync, four payload bytes MSB first, then (checksum build) the XOR byte or 00 when bad.
    task automatic send_frame(input logic [31:0] d, input bit bad_sum);
        logic [7:0] x;
        x = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        send_byte(8'hA5, 2);
        send_byte(d[31:24], 2);
        send_byte(d[23:16], 2);
        send_byte(d[15:8], 2);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_byte(d[7:0], 2);
        send_byte(bad_sum ? 8'h00 : x, 0);
`else
        send_byte(d[7:0], 0);
`endif
    endtask

    // Good frame: frame_valid must appear at the first edge after the final strobe edge.
    task automatic good_frame(input string tag, input logic [31:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b0);
        check({tag, "_fv_early"}, {31'd0, frame_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_fv"}, {31'd0, frame_valid}, 32'd1);
        check({tag, "_payload"}, payload, d);
        @(posedge clk); #1;
        check({tag, "_fv_one_cycle"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic force_error();
`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_frame(32'h11223344, 1'b1);
        repeat (2) @(negedge clk);
`else
        send_byte(8'hA5, 0);
        repeat (TO + 3) @(negedge clk);
`endif
    endtask

    // ---------------- directed sequence ----------------
    int exp_err;
    int fv_before, fe_before;

    initial begin
        exp_err = 0;
        #3;
        check("rst_payload", payload, 32'h0);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        check("rst_fe", {31'd0, frame_error}, 32'd0);
        check("rst_errcnt", {24'd0, error_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        release_reset();
        repeat (2) @(negedge clk);

        good_frame("basic", 32'h11223344);

`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_frame(32'h11223344, 1'b1);
        exp_err = 1;
        check("badsum_fe", {31'd0, frame_error}, 32'd1);
        check("badsum_payload", payload, 32'h11223344);
        check("badsum_errcnt", {24'd0, error_count}, exp_err);
        check("badsum_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
`endif

        // Noise in HUNT; second A5 is payload data.
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        check("hunt_noise_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(32'hA5010203);
        send_byte(8'hA5, 2);
        check("hunt_sync_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h02, 2);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_byte(8'h03, 2);
        send_byte(8'hA5, 4);
`else
        send_byte(8'h03, 4);
`endif
        check("noise_payload", payload, 32'hA5010203);

        // Timeout: gap count reaches 16 after 16 idle edges, error registered on the next.
        send_byte(8'hA5, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 0);
        repeat (TO) @(posedge clk);
        #1;
        check("to_not_yet_fe", {31'd0, frame_error}, 32'd0);
        check("to_not_yet_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        exp_err++;
        check("to_fe", {31'd0, frame_error}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_errcnt", {24'd0, error_count}, exp_err);
        check("to_payload", payload, 32'hA5010203);
        @(posedge clk); #1;
        check("to_fe_one_cycle", {31'd0, frame_error}, 32'd0);
        repeat (2) @(negedge clk);
        good_frame("after_to", 32'hDEADBEEF);

        // Strobe landing in the expiry cycle is accepted.
        fe_before = fe_cnt;
        exp_q.push_back(32'h01020304);
        send_byte(8'hA5, 2);
        send_byte(8'h01, TO - 1);
        send_byte(8'h02, 2);
        send_byte(8'h03, 2);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_byte(8'h04, 2);
        send_byte(8'h04, 4);
`else
        send_byte(8'h04, 4);
`endif
        check("edge_no_error", fe_cnt, fe_before);
        check("edge_payload", payload, 32'h01020304);

        // Reset mid-frame.
        send_byte(8'hA5, 2);
        send_byte(8'h11, 2);
        fv_before = fv_cnt;
        fe_before = fe_cnt;
        apply_reset();
        check("midrst_payload", payload, 32'h0);
        check("midrst_errcnt", {24'd0, error_count}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_fv", {31'd0, frame_valid}, 32'd0);
        release_reset();
        repeat (TO + 4) @(negedge clk);
        check("midrst_no_fv", fv_cnt, fv_before);
        check("midrst_no_fe", fe_cnt, fe_before);
        good_frame("after_rst", 32'h55667788);

        // Saturation of error_count.
        apply_reset();
        release_reset();
        exp_err = 0;
        fe_before = fe_cnt;
        for (int i = 0; i < 260; i++) begin
            force_error();
            if (exp_err < 255) exp_err++;
            check("sat_errcnt", {24'd0, error_count}, exp_err);
        end
        check("sat_pulses", fe_cnt - fe_before, 260);
        check("sat_final", {24'd0, error_count}, 32'd255);
        check("sat_payload", payload, 32'h0);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
